// File: rtl/periph_bus.sv
// periph_bus: memory-mapped I/O window at 0x4000_0xxx for the pipelined MIPS core.
// Hosts NUM_TIMERS reload timers (per-channel sub-module), LED/SSD registers,
// an optional free-running SysTick counter and a read-only IRQ status word.
// Reads are registered with one-cycle latency; IRQ/irq_id are combinational.
// Optional feature: define PERIPH_BUS_SYSTICK_EN to build SysTick at 0x40000108;
// otherwise that word reads 0 like any unmapped address.

// One reload timer channel: TH (reload), TL (counter), TCON {status, ie, en}.
module periph_bus_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_th,
  input  logic        we_tl,
  input  logic        we_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon
);
  logic cnt_en, wrap, ovf;

  // A CPU write to TH or TL takes priority over this cycle's count/reload.
  assign cnt_en = tcon[0] & ~we_th & ~we_tl;
  assign wrap   = (tl == 32'hFFFF_FFFF);
  assign ovf    = cnt_en & wrap & tcon[1];

  // Counter, reload and status; a same-cycle overflow beats a W1C clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (we_th) th <= wdata;
      if (we_tl) tl <= wdata;
      else if (cnt_en) tl <= wrap ? th : tl + 32'd1;
      if (we_tcon) tcon[1:0] <= wdata[1:0];
      tcon[2] <= ovf | (tcon[2] & ~(we_tcon & wdata[2]));
    end
  end
endmodule

module periph_bus #(
  parameter int NUM_TIMERS = 2,
  parameter int LED_W      = 8,
  parameter int SSD_W      = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRead,
  input  logic             MemWrite,
  input  logic [31:0]      address,
  input  logic [31:0]      write_data,
  output logic             sel,
  output logic [31:0]      read_data,
  output logic             rd_valid,
  output logic             IRQ,
  output logic [2:0]       irq_id,
  output logic [LED_W-1:0] led,
  output logic [SSD_W-1:0] ssd
);
  logic [NUM_TIMERS-1:0][31:0] th_q, tl_q;
  logic [NUM_TIMERS-1:0][2:0]  tcon_q;
  logic [NUM_TIMERS-1:0]       status;
  logic [NUM_TIMERS-1:0]       we_th, we_tl, we_tcon;
  logic [2:0]  slot, regi;
  logic        tmr_win, misc_win, wr_en, rd_en;
  logic [31:0] rd_mux;
  logic [1:0]  vld_pipe;
  logic        unused_addr;

  assign unused_addr = &{1'b0, address[1:0]};

  assign sel      = (address[31:12] == 20'h40000);
  assign wr_en    = MemWrite & sel;
  assign rd_en    = MemRead & sel;
  // Timer slots occupy 0x000..0x0FF (32 bytes each); misc regs 0x100..0x10F.
  assign tmr_win  = (address[11:8] == 4'h0);
  assign misc_win = (address[11:4] == 8'h10);
  assign slot     = address[7:5];
  assign regi     = address[4:2];

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_tmr
    assign we_th[n]   = wr_en & tmr_win & (slot == 3'(n)) & (regi == 3'd0);
    assign we_tl[n]   = wr_en & tmr_win & (slot == 3'(n)) & (regi == 3'd1);
    assign we_tcon[n] = wr_en & tmr_win & (slot == 3'(n)) & (regi == 3'd2);
    assign status[n]  = tcon_q[n][2];

    periph_bus_timer u_tmr (
      .clk     (clk),
      .reset   (reset),
      .we_th   (we_th[n]),
      .we_tl   (we_tl[n]),
      .we_tcon (we_tcon[n]),
      .wdata   (write_data),
      .th      (th_q[n]),
      .tl      (tl_q[n]),
      .tcon    (tcon_q[n])
    );
  end

`ifdef PERIPH_BUS_SYSTICK_EN
  logic [31:0] systick_q;

  // Free-running cycle counter, read-only.
  always_ff @(posedge clk) begin
    if (reset) systick_q <= '0;
    else       systick_q <= systick_q + 32'd1;
  end
`endif

  // LED and SSD registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      led <= '0;
      ssd <= '0;
    end else if (wr_en && misc_win) begin
      if (address[3:2] == 2'd0) led <= write_data[LED_W-1:0];
      if (address[3:2] == 2'd1) ssd <= write_data[SSD_W-1:0];
    end
  end

  // Read mux over pre-edge register state; unmapped words return 0.
  always_comb begin
    rd_mux = '0;
    if (tmr_win) begin
      for (int n = 0; n < NUM_TIMERS; n++) begin
        if (slot == 3'(n)) begin
          case (regi)
            3'd0:    rd_mux = th_q[n];
            3'd1:    rd_mux = tl_q[n];
            3'd2:    rd_mux = {29'd0, tcon_q[n]};
            default: rd_mux = '0;
          endcase
        end
      end
    end else if (misc_win) begin
      case (address[3:2])
        2'd0:    rd_mux[LED_W-1:0] = led;
        2'd1:    rd_mux[SSD_W-1:0] = ssd;
`ifdef PERIPH_BUS_SYSTICK_EN
        2'd2:    rd_mux = systick_q;
`endif
        2'd3:    rd_mux[NUM_TIMERS-1:0] = status;
        default: rd_mux = '0;
      endcase
    end
  end

  assign vld_pipe[0] = rd_en;
  assign rd_valid    = vld_pipe[1];

  // Registered read data; holds until the next accepted read.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      read_data   <= '0;
    end else begin
      vld_pipe[1] <= vld_pipe[0];
      if (rd_en) read_data <= rd_mux;
    end
  end

  // Lowest pending channel wins the IRQ ID.
  always_comb begin
    irq_id = '0;
    for (int n = NUM_TIMERS - 1; n >= 0; n--) begin
      if (status[n]) irq_id = 3'(n);
    end
  end

  assign IRQ = |status;
endmodule

// File: tb/tb_periph_bus.sv
// Directed bench for periph_bus (NUM_TIMERS=2, LED_W=8, SSD_W=12).
// Tasks are entered and left at a falling edge; outputs are sampled there.
module tb_periph_bus;
  logic        clk, reset, MemRead, MemWrite;
  logic [31:0] address, write_data;
  logic        sel, rd_valid, IRQ;
  logic [31:0] read_data;
  logic [2:0]  irq_id;
  logic [7:0]  led;
  logic [11:0] ssd;
  int          n_chk = 0, n_err = 0;
  logic [31:0] v, v1, v2;

  localparam logic [31:0] TH0 = 32'h4000_0000, TL0 = 32'h4000_0004, TC0 = 32'h4000_0008;
  localparam logic [31:0] TH1 = 32'h4000_0020, TL1 = 32'h4000_0024, TC1 = 32'h4000_0028;
  localparam logic [31:0] LEDA = 32'h4000_0100, SSDA = 32'h4000_0104;
  localparam logic [31:0] STKA = 32'h4000_0108, ISTA = 32'h4000_010C;

  periph_bus #(.NUM_TIMERS(2), .LED_W(8), .SSD_W(12)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .address(address), .write_data(write_data), .sel(sel),
    .read_data(read_data), .rd_valid(rd_valid), .IRQ(IRQ), .irq_id(irq_id),
    .led(led), .ssd(ssd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; address = a; write_data = d;
    @(negedge clk);
    MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    MemRead = 1'b1; address = a;
    @(negedge clk);
    MemRead = 1'b0;
    chk("rd_valid", {31'd0, rd_valid}, 32'd1);
    d = read_data;
  endtask

  initial begin
    reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; address = '0; write_data = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_rdv", {31'd0, rd_valid}, 0);
    chk("rst_rdata", read_data, 0);
    chk("rst_irq", {31'd0, IRQ}, 0);
    chk("rst_id", {29'd0, irq_id}, 0);
    reset = 1'b0;
    rd(TL0, v); chk("rst_tl0", v, 0);
    @(negedge clk); chk("rdv_pulse", {31'd0, rd_valid}, 0);

    // LED / SSD truncation and zero-extended readback
    wr(LEDA, 32'h1FF); chk("led", {24'd0, led}, 32'hFF);
    rd(LEDA, v); chk("led_rd", v, 32'hFF);
    wr(SSDA, 32'hABCDE); chk("ssd", {20'd0, ssd}, 32'hCDE);
    rd(SSDA, v); chk("ssd_rd", v, 32'hCDE);

    // Timer 1 overflow and reload
    wr(TH1, 32'hFFFF_FFFD);
    wr(TL1, 32'hFFFF_FFFE);
    wr(TC1, 32'h3);
    rd(TL1, v); chk("tl1_a", v, 32'hFFFF_FFFE);
    chk("irq_pre", {31'd0, IRQ}, 0);
    rd(TL1, v); chk("tl1_b", v, 32'hFFFF_FFFF);
    chk("irq_post", {31'd0, IRQ}, 1);
    chk("id_1", {29'd0, irq_id}, 1);
    rd(TL1, v); chk("tl1_reload", v, 32'hFFFF_FFFD);
    rd(ISTA, v); chk("istat_2", v, 32'h2);
    rd(TC1, v); chk("tcon1", v, 32'h7);

    // Both channels pending, then clear in turn
    wr(TL0, 32'hFFFF_FFFF);
    wr(TC0, 32'h3);
    @(negedge clk);
    chk("id_both", {29'd0, irq_id}, 0);
    wr(TC0, 32'h7);
    chk("id_after_w1c", {29'd0, irq_id}, 1);
    chk("irq_still", {31'd0, IRQ}, 1);
    wr(TC1, 32'h2);
    wr(TC1, 32'h4);
    chk("irq_clr", {31'd0, IRQ}, 0);
    chk("id_clr", {29'd0, irq_id}, 0);
    rd(ISTA, v); chk("istat_0", v, 0);

    // W1C on the overflow edge: set wins
    wr(TC0, 32'h0);
    wr(TL0, 32'hFFFF_FFFF);
    wr(TC0, 32'h3);
    wr(TC0, 32'h7);
    rd(ISTA, v); chk("w1c_vs_ovf", v, 32'h1);
    chk("id_0", {29'd0, irq_id}, 0);

    // Simultaneous read and write returns pre-write value
    wr(TC0, 32'h4);
    wr(TL0, 32'h55);
    MemRead = 1'b1; MemWrite = 1'b1; address = TL0; write_data = 32'h10;
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    chk("raw_old", read_data, 32'h55);
    rd(TL0, v); chk("raw_new", v, 32'h10);

    // Unmapped words and ignored writes
    wr(32'h4000_0060, 32'hDEAD_BEEF);
    rd(32'h4000_0060, v); chk("slot3", v, 0);
    rd(32'h4000_002C, v); chk("slot_gap", v, 0);
    wr(ISTA, 32'hFFFF_FFFF);
    rd(ISTA, v); chk("istat_ro", v, 0);
    rd(TH1, v); chk("th1", v, 32'hFFFF_FFFD);

    // Out-of-window read: no rd_valid, read_data held
    MemRead = 1'b1; address = 32'h3000_0100;
    #1 chk("sel_lo", {31'd0, sel}, 0);
    @(negedge clk);
    MemRead = 1'b0;
    chk("nosel_rdv", {31'd0, rd_valid}, 0);
    chk("nosel_hold", read_data, 32'hFFFF_FFFD);
    address = LEDA;
    #1 chk("sel_hi", {31'd0, sel}, 1);

    // SysTick back-to-back reads
    MemRead = 1'b1; address = STKA;
    @(negedge clk); v1 = read_data;
    @(negedge clk); v2 = read_data;
    MemRead = 1'b0;
    chk("stk_rdv", {31'd0, rd_valid}, 1);
`ifdef PERIPH_BUS_SYSTICK_EN
    chk("stk_inc", v2, v1 + 32'd1);
    chk("stk_nz", {31'd0, v1 != 0}, 1);
`else
    chk("stk_off_a", v1, 0);
    chk("stk_off_b", v2, 0);
`endif

    // Reset wins over a concurrent read and clears state
    wr(LEDA, 32'h5A);
    wr(TC1, 32'h3);
    MemRead = 1'b1; address = LEDA; reset = 1'b1;
    @(negedge clk);
    MemRead = 1'b0; reset = 1'b0;
    chk("rst2_rdv", {31'd0, rd_valid}, 0);
    chk("rst2_rdata", read_data, 0);
    chk("rst2_led", {24'd0, led}, 0);
    chk("rst2_irq", {31'd0, IRQ}, 0);
    rd(TC1, v); chk("rst2_tc1", v, 0);
    rd(TL1, v); chk("rst2_tl1", v, 0);
    rd(TH1, v); chk("rst2_th1", v, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
